// File: rtl/seg7_display_scanner_pkg.sv
// Shared constants for the seven-segment display scanner: glyphs, converter
// state encoding and the double-dabble nibble adjust helper.
package seg7_display_scanner_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Decimal glyph for one BCD nibble; non-decimal codes render blank
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift
    function automatic logic [19:0] bcd_adjust(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_display_scanner_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-and-add-3).
// Start is honoured only in ST_IDLE; done pulses for the single COMMIT cycle.
module bin2bcd_seq
    import seg7_display_scanner_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] binary,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_t r_state;
    conv_state_t w_state_next;
    logic [15:0] r_bin;
    logic [15:0] w_bin_next;
    logic [19:0] r_bcd;
    logic [19:0] w_bcd_next;
    logic [19:0] w_bcd_adj;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    assign w_bcd_adj = bcd_adjust(r_bcd);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bin   <= 16'd0;
            r_bcd   <= 20'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_bcd   <= w_bcd_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: capture on start, 16 shift steps, one commit cycle
    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_bcd_next   = r_bcd;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bin_next   = binary;
                    w_bcd_next   = 20'd0;
                    w_cnt_next   = 4'd0;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bcd_next = {w_bcd_adj[18:0], r_bin[15]};
                w_bin_next = {r_bin[14:0], 1'b0};
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_COMMIT);
    assign bcd  = r_bcd;

endmodule

// File: rtl/seg7_display_scanner.sv
// Four-digit multiplexed seven-segment display driver fed by a sequential
// binary-to-BCD converter, with optional leading-zero blanking.
module seg7_display_scanner
    import seg7_display_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned AUTO_LOAD     = 1,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] binary,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  seven_segment,
    output logic [3:0]  enable,
    output logic [3:0]  leds
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic            w_start;
    logic            w_busy;
    logic            w_done;
    logic [19:0]     w_bcd;
    logic [15:0]     r_last;
    logic [19:0]     r_disp;
    logic [CntW-1:0] r_refresh;
    logic [1:0]      r_index;
    logic [3:0]      r_enable;
    logic [6:0]      r_seg;
    logic [3:0]      w_blank;
    logic [3:0]      w_digit;

    assign w_start = load | ((AUTO_LOAD != 0) & (binary != r_last));

    bin2bcd_seq u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start),
        .binary (binary),
        .busy   (w_busy),
        .done   (w_done),
        .bcd    (w_bcd)
    );

    // Remember the value handed to the converter; display only whole results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 16'd0;
            r_disp <= 20'd0;
        end else begin
            if (w_start && !w_busy) begin
                r_last <= binary;
            end
            if (w_done) begin
                r_disp <= w_bcd;
            end
        end
    end

    // Free-running refresh timer stepping the digit index on each wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_index   <= 2'd0;
        end else if (r_refresh == CntW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_index   <= r_index + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Leading-zero blanking: a digit blanks only if it and all above it are zero
    always_comb begin
        w_blank = 4'b0000;
        if (BLANK_LEADING != 0) begin
            w_blank[3] = (r_disp[15:12] == 4'd0) && (r_disp[19:16] == 4'd0);
            w_blank[2] = (r_disp[11:8] == 4'd0) && w_blank[3];
            w_blank[1] = (r_disp[7:4] == 4'd0) && w_blank[2];
        end
    end

    assign w_digit = r_disp[{r_index, 2'b00} +: 4];

    // Anode and glyph registered together so they switch on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 4'b1110;
            r_seg    <= SEG_0;
        end else begin
            r_enable <= ~(4'b0001 << r_index);
            r_seg    <= w_blank[r_index] ? SEG_BLANK : seg_glyph(w_digit);
        end
    end

    assign busy          = w_busy;
    assign enable        = r_enable;
    assign seven_segment = r_seg;
    assign leds          = r_disp[19:16];

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Directed bench: instance A auto-loads with blanking, instance B converts on
// load only and shows all four digits.
module tb_seg7_display_scanner;

    localparam int unsigned Div = 4;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [15:0] bin_a = 16'd0;
    logic [15:0] bin_b = 16'd0;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic        busy_a, busy_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  en_a, en_b;
    logic [3:0]  leds_a, leds_b;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [6:0]  seen [4];
    int          nb;

    seg7_display_scanner #(
        .REFRESH_DIV   (Div),
        .AUTO_LOAD     (1),
        .BLANK_LEADING (1)
    ) u_dut_a (
        .clk           (clk),
        .reset         (rst_a),
        .binary        (bin_a),
        .load          (load_a),
        .busy          (busy_a),
        .seven_segment (seg_a),
        .enable        (en_a),
        .leds          (leds_a)
    );

    seg7_display_scanner #(
        .REFRESH_DIV   (Div),
        .AUTO_LOAD     (0),
        .BLANK_LEADING (0)
    ) u_dut_b (
        .clk           (clk),
        .reset         (rst_b),
        .binary        (bin_b),
        .load          (load_b),
        .busy          (busy_b),
        .seven_segment (seg_b),
        .enable        (en_b),
        .leds          (leds_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count negedges on which busy stays high, starting with the current one
    task automatic count_busy(input bit sel, output int n);
        n = 0;
        while ((sel ? busy_b : busy_a) && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Sample every digit slot over two full scan rounds
    task automatic scan(input bit sel);
        logic [3:0] en;
        for (int i = 0; i < 4; i++) seen[i] = 7'h55;
        for (int c = 0; c < 8 * Div; c++) begin
            @(negedge clk);
            en = sel ? en_b : en_a;
            case (en)
                4'b1110: seen[0] = sel ? seg_b : seg_a;
                4'b1101: seen[1] = sel ? seg_b : seg_a;
                4'b1011: seen[2] = sel ? seg_b : seg_a;
                4'b0111: seen[3] = sel ? seg_b : seg_a;
                default: begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scan_enable: got %b expected one-hot-low", en);
                end
            endcase
        end
    endtask

    task automatic check_digits(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                                input logic [6:0] d2, input logic [6:0] d3);
        check_val({tag, "_d0"}, 32'(seen[0]), 32'(d0));
        check_val({tag, "_d1"}, 32'(seen[1]), 32'(d1));
        check_val({tag, "_d2"}, 32'(seen[2]), 32'(d2));
        check_val({tag, "_d3"}, 32'(seen[3]), 32'(d3));
    endtask

    initial begin
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check_val("rst_enable", 32'(en_a), 32'(4'b1110));
        check_val("rst_seg", 32'(seg_a), 32'(7'b1000000));
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_leds", 32'(leds_a), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        check_val("post_rst_idle_a", 32'(busy_a), 32'd0);
        check_val("post_rst_idle_b", 32'(busy_b), 32'd0);

        // 1234 auto-load
        bin_a = 16'd1234;
        @(negedge clk);
        count_busy(1'b0, nb);
        check_val("busy_len_1234", 32'(nb), 32'd17);
        scan(1'b0);
        check_digits("v1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        check_val("leds_1234", 32'(leds_a), 32'd0);

        // 65535: maximum value
        bin_a = 16'd65535;
        @(negedge clk);
        count_busy(1'b0, nb);
        check_val("busy_len_65535", 32'(nb), 32'd17);
        scan(1'b0);
        check_digits("v65535", 7'b0010010, 7'b0110000, 7'b0010010, 7'b0010010);
        check_val("leds_65535", 32'(leds_a), 32'd6);

        // 7: leading zeros blank
        bin_a = 16'd7;
        @(negedge clk);
        count_busy(1'b0, nb);
        scan(1'b0);
        check_digits("v7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
        check_val("leds_7", 32'(leds_a), 32'd0);

        // 500 interrupted by reset on the 8th shift cycle
        bin_a = 16'd500;
        @(negedge clk);
        check_val("busy_500_start", 32'(busy_a), 32'd1);
        repeat (7) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check_val("midrst_busy", 32'(busy_a), 32'd0);
        check_val("midrst_seg", 32'(seg_a), 32'(7'b1000000));
        check_val("midrst_enable", 32'(en_a), 32'(4'b1110));
        check_val("midrst_leds", 32'(leds_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        count_busy(1'b0, nb);
        check_val("busy_len_500", 32'(nb), 32'd17);
        scan(1'b0);
        check_digits("v500", 7'b1000000, 7'b1000000, 7'b0010010, 7'b1111111);

        // Instance B: load-only, value change mid-conversion ignored
        bin_b = 16'd42;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        check_val("b_busy_start", 32'(busy_b), 32'd1);
        repeat (4) @(negedge clk);
        bin_b = 16'd99;
        count_busy(1'b1, nb);
        check_val("b_busy_rest", 32'(nb), 32'd13);
        scan(1'b1);
        check_digits("b42", 7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000);
        repeat (10) @(negedge clk);
        check_val("b_no_auto", 32'(busy_b), 32'd0);
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        count_busy(1'b1, nb);
        check_val("b_busy_len_99", 32'(nb), 32'd17);
        scan(1'b1);
        check_digits("b99", 7'b0010000, 7'b0010000, 7'b1000000, 7'b1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
